// File: rtl/ifu_prefetch_pkg.sv
// rtl/ifu_prefetch_pkg.sv - shared defines and package for the prefetching fetch unit
`ifndef IFU_PREFETCH_DEFINES
`define IFU_PREFETCH_DEFINES
`define XLEN_WIDTH 32
`define RESET_PC_DEFAULT 32'h0000_0000
`define INST_NOP 32'h0000_0013
`endif

package ifu_prefetch_pkg;

  localparam int unsigned INST_BYTES = 4;

  // Occupancy counters must hold the value DEPTH itself, not just DEPTH-1.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_prefetch_sync_fifo.sv
// rtl/ifu_prefetch_sync_fifo.sv - synchronous FIFO with flush, used for the queue and the PC tags
module ifu_prefetch_sync_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = cnt_width(DEPTH),
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - fetch unit issuing credited ROM requests into a prefetch queue
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned          XLEN     = `XLEN_WIDTH,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = `RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            rom_req_valid,
  input  logic            rom_req_ready,
  output logic [XLEN-1:0] rom_addr,
  input  logic            rom_resp_valid,
  input  logic [XLEN-1:0] rom_resp_data,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     drop;
  logic              req_fire;
  logic              keep_resp;
  logic [CW:0]       credit_used;

  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;
  logic [2*XLEN-1:0] q_head;
  logic              t_full;
  logic              t_empty;
  logic [CW-1:0]     t_count;
  logic [XLEN-1:0]   t_head;
  logic              unused_flags;

  // Queue slots already holding words plus slots reserved for in-flight words.
  assign credit_used   = {1'b0, q_count} + {1'b0, outstanding};
  assign rom_req_valid = !rst && !redirect_en && (credit_used < (CW+1)'(DEPTH));
  assign rom_addr      = fetch_pc;
  assign req_fire      = rom_req_valid && rom_req_ready;
  assign keep_resp     = rom_resp_valid && (drop == '0);

  assign outstanding_next = outstanding + CW'(req_fire) - CW'(rom_resp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_en) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        drop     <= outstanding_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
        if (rom_resp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // Tags are only consumed by kept responses, so after a flush the tag
  // FIFO lines up exactly with the responses that will be pushed.
  ifu_prefetch_sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (keep_resp),
    .flush (redirect_en),
    .data  (fetch_pc),
    .full  (t_full),
    .empty (t_empty),
    .count (t_count),
    .head  (t_head)
  );

  ifu_prefetch_sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep_resp),
    .pop   (inst_valid && inst_ready),
    .flush (redirect_en),
    .data  ({t_head, rom_resp_data}),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  assign inst_valid = !rst && !q_empty;
  assign inst_pc    = q_head[2*XLEN-1:XLEN];
  assign inst       = q_head[XLEN-1:0];

  assign unused_flags = &{1'b0, q_full, t_full, t_empty, t_count};

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed vector bench for ifu_prefetch
module tb_ifu_prefetch;

  logic        clk;
  logic        rst;
  logic        rom_req_valid;
  logic        rom_req_ready;
  logic [31:0] rom_addr;
  logic        rom_resp_valid;
  logic [31:0] rom_resp_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic        w_req_valid;
  logic [31:0] w_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;

  int checks;
  int errors;

  logic        pv [4];
  logic [31:0] pa [4];
  logic [1:0]  lat_sel;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ins;
  } vec_t;

  vec_t        tbl [22];
  logic [31:0] wrap_exp [3];

  ifu_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .rom_req_valid  (rom_req_valid),
    .rom_req_ready  (rom_req_ready),
    .rom_addr       (rom_addr),
    .rom_resp_valid (rom_resp_valid),
    .rom_resp_data  (rom_resp_data),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  ifu_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .rom_req_valid  (w_req_valid),
    .rom_req_ready  (1'b1),
    .rom_addr       (w_addr),
    .rom_resp_valid (w_resp_valid),
    .rom_resp_data  (w_resp_data),
    .redirect_en    (1'b0),
    .redirect_pc    (32'h0),
    .inst_valid     (w_inst_valid),
    .inst_ready     (1'b1),
    .inst           (w_inst),
    .inst_pc        (w_inst_pc)
  );

  always #5 clk = ~clk;

  // ROM models: returned word is addr>>2, latency selectable 1..4 for the main DUT.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= rom_req_valid && rom_req_ready;
      pa[0] <= rom_addr;
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end
  assign rom_resp_valid = pv[lat_sel];
  assign rom_resp_data  = pa[lat_sel] >> 2;

  always @(posedge clk) begin
    if (rst) begin
      w_resp_valid <= 1'b0;
    end else begin
      w_resp_valid <= w_req_valid;
      w_resp_data  <= w_addr >> 2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1;
    lat_sel = 2'(lat - 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst = 1'b1; checks = 0; errors = 0;
    rom_req_ready = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0;
    inst_ready = 1'b1; lat_sel = 2'd0;

    tbl[0]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd1};
    tbl[4]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd2};
    tbl[5]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd3};
    tbl[6]  = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd4};
    tbl[7]  = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd4};
    tbl[8]  = '{1'b0, 1'b0, 32'd0,  1'b1, 32'd4};
    for (int i = 9; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 32'd0, 1'b1, 32'd4};
    tbl[16] = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd4};
    tbl[17] = '{1'b1, 1'b1, 32'd32, 1'b1, 32'd5};
    tbl[18] = '{1'b1, 1'b1, 32'd36, 1'b1, 32'd6};
    tbl[19] = '{1'b1, 1'b1, 32'd40, 1'b1, 32'd7};
    tbl[20] = '{1'b1, 1'b1, 32'd44, 1'b1, 32'd8};
    tbl[21] = '{1'b1, 1'b1, 32'd48, 1'b1, 32'd9};
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_req_valid", rom_req_valid, 0);
    chk("rst_wrap_inst_valid", w_inst_valid, 0);
    rst = 1'b0;

    // Free run then backpressure, one row per cycle.
    for (int i = 0; i < 22; i++) begin
      inst_ready = tbl[i].rdy;
      #1;
      chk($sformatf("req_valid[%0d]", i), rom_req_valid, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("rom_addr[%0d]", i), rom_addr, tbl[i].addr);
      chk($sformatf("inst_valid[%0d]", i), inst_valid, tbl[i].iv);
      if (tbl[i].iv) begin
        chk($sformatf("inst[%0d]", i), inst, tbl[i].ins);
        chk($sformatf("inst_pc[%0d]", i), inst_pc, tbl[i].ins << 2);
      end
      if (i >= 2 && i <= 4) begin
        chk($sformatf("wrap_valid[%0d]", i), w_inst_valid, 1);
        chk($sformatf("wrap_pc[%0d]", i), w_inst_pc, wrap_exp[i-2]);
        chk($sformatf("wrap_inst[%0d]", i), w_inst, wrap_exp[i-2] >> 2);
      end
      @(negedge clk);
    end

    // Redirect with two responses in flight, 3-cycle ROM.
    inst_ready = 1'b1;
    do_reset(3);
    @(negedge clk);
    @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h100;
    #1;
    chk("redir_req_blocked", rom_req_valid, 0);
    @(negedge clk);
    redirect_en = 1'b0;
    #1;
    chk("redir_req_valid", rom_req_valid, 1);
    chk("redir_req_addr", rom_addr, 32'h100);
    for (int j = 0; j < 4; j++) begin
      #1;
      chk($sformatf("redir_drop_valid[%0d]", j), inst_valid, 0);
      @(negedge clk);
    end
    #1;
    chk("redir_first_valid", inst_valid, 1);
    chk("redir_first_pc", inst_pc, 32'h100);
    chk("redir_first_inst", inst, 32'h40);
    @(negedge clk);
    #1;
    chk("redir_second_pc", inst_pc, 32'h104);
    chk("redir_second_inst", inst, 32'h41);

    // Redirect on the same cycle as a response and a pop, 1-cycle ROM.
    @(negedge clk);
    do_reset(1);
    repeat (4) @(negedge clk);
    redirect_en = 1'b1; redirect_pc = 32'h203;
    #1;
    chk("coin_pre_pc", inst_pc, 32'h8);
    chk("coin_req_blocked", rom_req_valid, 0);
    @(negedge clk);
    redirect_en = 1'b0;
    #1;
    chk("coin_empty", inst_valid, 0);
    chk("coin_req_valid", rom_req_valid, 1);
    chk("coin_req_addr", rom_addr, 32'h200);
    @(negedge clk);
    #1;
    chk("coin_wait_valid", inst_valid, 0);
    @(negedge clk);
    #1;
    chk("coin_first_valid", inst_valid, 1);
    chk("coin_first_pc", inst_pc, 32'h200);
    chk("coin_first_inst", inst, 32'h80);
    @(negedge clk);
    #1;
    chk("coin_second_pc", inst_pc, 32'h204);
    chk("coin_second_inst", inst, 32'h81);

    // Reset with three queued words and one in flight.
    @(negedge clk);
    inst_ready = 1'b0;
    do_reset(1);
    repeat (4) @(negedge clk);
    #1;
    chk("mid_full_credit", rom_req_valid, 0);
    chk("mid_head_pc", inst_pc, 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", inst_valid, 0);
    @(negedge clk);
    rst = 1'b0; inst_ready = 1'b1;
    #1;
    chk("mid_after_valid", inst_valid, 0);
    chk("mid_after_req", rom_req_valid, 1);
    chk("mid_after_addr", rom_addr, 32'h0);
    @(negedge clk);
    #1;
    chk("mid_wait_valid", inst_valid, 0);
    @(negedge clk);
    #1;
    chk("mid_first_valid", inst_valid, 1);
    chk("mid_first_pc", inst_pc, 32'h0);
    chk("mid_first_inst", inst, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with a prefetch queue, successor to the single-word `ifu`. It owns the fetch PC, issues sequential word requests to the instruction ROM under a credit limit, and buffers returned words with their PCs in a DEPTH-entry FIFO. It presents them to `id` over a valid/ready handshake. A redirect from `ex` flushes the queue and discards in-flight responses, so `id` never sees wrong-path instructions.

## Interface
- XLEN, 32, data/address width; equals the width of `XLEN_WIDTH`.
- DEPTH, 4, queue entries and maximum outstanding ROM requests; power of two, ≥2.
- RESET_PC, 0, fetch PC after reset; word aligned.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_req_valid  out  1  request for the word at rom_addr.
- rom_req_ready  in  1  ROM accepts the request this cycle.
- rom_addr  out  XLEN  byte address of the requested word.
- rom_resp_valid  in  1  response word present; responses return in request order.
- rom_resp_data  in  XLEN  returned instruction word.
- redirect_en  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  `id` consumes the head this cycle.
- inst  out  XLEN  head instruction.
- inst_pc  out  XLEN  PC of the head instruction.

## Operation
- Reset (rst=1 at an edge):
  - fetch_pc ← RESET_PC.
  - Queue emptied; outstanding ← 0; drop ← 0.
  - Outputs while rst=1: inst_valid=0 and rom_req_valid=0. inst and inst_pc are don't-care.
- Credit rule: rom_req_valid = !rst && !redirect_en && (count + outstanding < DEPTH), with rom_addr = fetch_pc. Every accepted response therefore has a reserved slot, and the queue can never overflow.
- Accepted request (valid && ready):
  - fetch_pc ← fetch_pc + 4, wrapping modulo 2^XLEN.
  - outstanding increments.
- Response arrival:
  - outstanding decrements.
  - If drop > 0: drop decrements and the word is discarded.
  - Otherwise {data, pc} is pushed. The PC comes from a DEPTH-entry in-flight PC tag FIFO, or equivalently a resp_pc register that advances by 4 per kept response.
- Pop: when inst_valid && inst_ready.
- Redirect (redirect_en=1 at an edge):
  - Queue emptied; any same-cycle pop or push is ignored.
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - drop ← outstanding_next, i.e. current outstanding minus 1 if a response arrives this cycle (counted as dropped) plus 0, since no request is issued on a redirect cycle.
- Redirect has priority over reset-free activity but not over rst.
- Back-to-back redirects are legal. Each one recomputes drop from the live outstanding count.
- Counter widths: $clog2(DEPTH+1). Invariant: count + outstanding ≤ DEPTH, and drop ≤ outstanding.

## Timing
- rom_req_valid and rom_addr are combinational from registered state and redirect_en.
- inst, inst_pc and inst_valid come straight from the FIFO head registers. There is no response-to-output bypass.
- Minimum latency:
  - Request accepted at edge N.
  - Response at edge N+1 or later.
  - inst_valid visible in the cycle after the push edge.
  - First instruction after rst falls before edge R: request at R, inst_valid from R+2 with a 1-cycle ROM.
- Throughput: 1 instruction per cycle sustained with DEPTH ≥ ROM latency + 1 and inst_ready held high.
- Full queue with simultaneous pop: the credit freed by the pop is usable the following cycle, not combinationally.
- Empty queue: inst_valid=0 and inst_ready is ignored.

## Structure
- Shared `defines` header:
  - `XLEN_WIDTH` and the RESET_PC default macro.
  - `INST_NOP` (32'h00000013), used by benches for fill.
- One natural sub-module: `sync_fifo` (parameters WIDTH and DEPTH; ports push, pop, flush, full, empty, count, head). It is instantiated twice: the data+PC queue at width 2×XLEN, and the in-flight PC tag FIFO at width XLEN.
- Top level: credit, drop and fetch_pc logic only.

## Test plan
- Reset then free run: 1-cycle ROM returning addr>>2, inst_ready=1. Expected: inst_pc 0,4,8,… with inst 0,1,2,… on consecutive cycles from R+2, with no gaps.
- Backpressure: inst_ready=0 for 10 cycles (DEPTH=4). Expected: exactly 4 requests issued, then rom_req_valid stays 0. On release, PCs continue in order with none lost or duplicated.
- Redirect with 2 in flight: 3-cycle ROM latency, redirect_pc=0x100 while outstanding=2. Expected: both late responses dropped; the first inst_valid shows inst_pc=0x100.
- Redirect coinciding with a response and a pop: redirect_pc=0x203. Expected: queue empty next cycle; fetch restarts at 0x200; the concurrent response is discarded.
- Wrap: RESET_PC=0xFFFFFFF8, XLEN=32. Expected: inst_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-stream: assert rst with a queue of 3 and 1 outstanding. Expected: inst_valid=0 at the next edge. After release, fetch restarts at RESET_PC; the pre-reset response is not accepted because the ROM is also reset.
